drenador_salidas: RTL and testbench

Output-side drain and word counter for the transaction layer. It pops the four output FIFOs (p0–p3) in round-robin order and presents each popped word on one registered output stream, tagged with its source port. It keeps per-port and total word counters that are read through the `req`/`idx` handshake. It sits directly after the four output FIFOs and is the consuming end of their pop/empty interface.

---
 rtl/drenador_salidas.sv | 119 +++++++++++
 tb/tb_drenador_salidas.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/drenador_salidas.sv
// Round-robin drain of the four output FIFOs onto one registered stream, with per-port
// and total word counters readable through a req/idx handshake.
module drenador_salidas #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Enable,
    input  logic [3:0]            fifo_empty,
    input  logic [DATA_WIDTH-1:0] data_in_p0,
    input  logic [DATA_WIDTH-1:0] data_in_p1,
    input  logic [DATA_WIDTH-1:0] data_in_p2,
    input  logic [DATA_WIDTH-1:0] data_in_p3,
    output logic [3:0]            pop_fifo_azules,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [1:0]            port_out,
    input  logic                  req,
    input  logic [2:0]            idx,
    output logic [CNT_WIDTH-1:0]  salida_contador,
    output logic                  valid_contador,
    output logic                  idle
);

    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    logic [1:0]            ptr_q;
    logic                  pending_q;
    logic [1:0]            port_q;
    logic [CNT_WIDTH-1:0]  cnt_q [4];
    logic [CNT_WIDTH-1:0]  total_q;

    logic                  grant_valid;
    logic [1:0]            grant;
    logic [1:0]            cand;
    logic [DATA_WIDTH-1:0] sel_data;

    // Scan offsets from farthest to nearest so the nearest non-empty port wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = ptr_q;
        cand        = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (Enable && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant       = cand;
            end
        end
    end

    always_comb begin
        pop_fifo_azules = 4'b0000;
        if (grant_valid) begin
            pop_fifo_azules[grant] = 1'b1;
        end
    end

    always_comb begin
        unique case (port_q)
            2'd0:    sel_data = data_in_p0;
            2'd1:    sel_data = data_in_p1;
            2'd2:    sel_data = data_in_p2;
            default: sel_data = data_in_p3;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q           <= 2'd0;
            pending_q       <= 1'b0;
            port_q          <= 2'd0;
            data_out        <= '0;
            valid_out       <= 1'b0;
            port_out        <= 2'd0;
            total_q         <= '0;
            salida_contador <= '0;
            valid_contador  <= 1'b0;
            idle            <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pending_q <= grant_valid;
            if (grant_valid) begin
                port_q <= grant;
                ptr_q  <= grant + 2'd1;
            end

            valid_out <= pending_q;
            if (pending_q) begin
                data_out      <= sel_data;
                port_out      <= port_q;
                cnt_q[port_q] <= cnt_q[port_q] + CntOne;
                total_q       <= total_q + CntOne;
            end

            idle <= !pending_q && (&fifo_empty);

            // Reads see the counters as they were before this edge's increment.
            if (req) begin
                if (idx < 3'd4) begin
                    salida_contador <= cnt_q[idx[1:0]];
                    valid_contador  <= 1'b1;
                end else if (idx == 3'd4) begin
                    salida_contador <= total_q;
                    valid_contador  <= 1'b1;
                end else begin
                    salida_contador <= '0;
                    valid_contador  <= 1'b0;
                end
            end else begin
                valid_contador <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_drenador_salidas.sv
// Bench for drenador_salidas: queue-based FIFO/counter reference model, directed scenarios
// followed by randomized traffic, enable and counter reads.
module tb_drenador_salidas;

    logic        clk;
    logic        reset;
    logic        Enable;
    logic [3:0]  fifo_empty;
    logic [11:0] din [4];
    logic [3:0]  pop;
    logic [11:0] data_out;
    logic        valid_out;
    logic [1:0]  port_out;
    logic        req;
    logic [2:0]  idx;
    logic [7:0]  salida;
    logic        valid_contador;
    logic        idle;

    drenador_salidas #(.DATA_WIDTH(12), .CNT_WIDTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .Enable          (Enable),
        .fifo_empty      (fifo_empty),
        .data_in_p0      (din[0]),
        .data_in_p1      (din[1]),
        .data_in_p2      (din[2]),
        .data_in_p3      (din[3]),
        .pop_fifo_azules (pop),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .port_out        (port_out),
        .req             (req),
        .idx             (idx),
        .salida_contador (salida),
        .valid_contador  (valid_contador),
        .idle            (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, next port to try, word in flight, word counters.
    logic [11:0] fq [4][$];
    int          ptr;
    bit          m_pending;
    int          m_port;
    logic [11:0] m_word;
    int          cnt [5];
    logic [3:0]  exp_pop;
    logic [11:0] exp_data;
    logic        exp_valid;
    logic [1:0]  exp_port;
    logic [7:0]  exp_sal;
    logic        exp_vc;
    logic        exp_idle;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic upd_empty();
        for (int p = 0; p < 4; p++) fifo_empty[p] = (fq[p].size() == 0);
    endtask

    task automatic push(int p, logic [11:0] w);
        fq[p].push_back(w);
        upd_empty();
    endtask

    function automatic bit all_empty();
        return fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0 && fq[3].size() == 0;
    endfunction

    task automatic check_outputs();
        chk("valid_out", 32'(valid_out), 32'(exp_valid));
        chk("data_out", 32'(data_out), 32'(exp_data));
        chk("port_out", 32'(port_out), 32'(exp_port));
        chk("salida_contador", 32'(salida), 32'(exp_sal));
        chk("valid_contador", 32'(valid_contador), 32'(exp_vc));
        chk("idle", 32'(idle), 32'(exp_idle));
    endtask

    task automatic model_reset();
        for (int p = 0; p < 4; p++) fq[p].delete();
        for (int i = 0; i < 5; i++) cnt[i] = 0;
        ptr = 0; m_pending = 0; m_port = 0; m_word = '0;
        exp_data = '0; exp_valid = 0; exp_port = '0;
        exp_sal = '0; exp_vc = 0; exp_idle = 1;
        upd_empty();
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle();
        int g;
        g = -1;
        @(negedge clk);
        if (Enable) begin
            for (int k = 3; k >= 0; k--) begin
                if (fq[(ptr + k) % 4].size() > 0) g = (ptr + k) % 4;
            end
        end
        exp_pop = (g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("pop_fifo_azules", 32'(pop), 32'(exp_pop));
        @(posedge clk);
        if (req) begin
            if (idx < 5) begin
                exp_sal = 8'(cnt[idx]);
                exp_vc  = 1;
            end else begin
                exp_sal = '0;
                exp_vc  = 0;
            end
        end else begin
            exp_vc = 0;
        end
        exp_idle = !m_pending && all_empty();
        if (m_pending) begin
            exp_valid   = 1;
            exp_data    = m_word;
            exp_port    = 2'(m_port);
            cnt[m_port] = (cnt[m_port] + 1) % 256;
            cnt[4]      = (cnt[4] + 1) % 256;
        end else begin
            exp_valid = 0;
        end
        if (g >= 0) begin
            m_word    = fq[g].pop_front();
            m_port    = g;
            m_pending = 1;
            ptr       = (g + 1) % 4;
        end else begin
            m_pending = 0;
        end
        #1;
        for (int p = 0; p < 4; p++) din[p] = 12'($urandom);
        if (m_pending) din[m_port] = m_word;
        upd_empty();
        check_outputs();
    endtask

    task automatic drain(int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (all_empty() && !m_pending) begin
                done = 1;
                break;
            end
        end
        chk("drain_done", 32'(done), 32'd1);
        cycle();
    endtask

    task automatic read_cnt(int i);
        req = 1; idx = 3'(i);
        cycle();
        req = 0;
    endtask

    // Asynchronous assertion mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1;
        model_reset();
        #1;
        chk("reset_pop", 32'(pop), 32'd0);
        check_outputs();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        reset = 0; Enable = 1; req = 0; idx = '0;
        for (int p = 0; p < 4; p++) din[p] = '0;
        model_reset();
        #2;
        reset = 1;
        #1;
        chk("reset_pop", 32'(pop), 32'd0);
        check_outputs();
        @(posedge clk);
        #1;
        reset = 0;

        // Counters read as zero right after reset.
        for (int i = 0; i < 5; i++) read_cnt(i);
        cycle();

        // Single port p2.
        push(2, 12'hAAA); push(2, 12'hACC); push(2, 12'hAF3);
        drain(20);
        read_cnt(2); read_cnt(4);
        cycle();

        // Round-robin over all four ports.
        do_reset();
        push(0, 12'h0AA); push(0, 12'h0CC); push(1, 12'h5AA); push(1, 12'h5CC);
        push(2, 12'hAAA); push(2, 12'hACC); push(3, 12'hFAA); push(3, 12'hFCC);
        drain(30);
        for (int i = 0; i < 5; i++) read_cnt(i);

        // Enable gating right after a pop to p1.
        push(1, 12'h111); push(1, 12'h112); push(1, 12'h113);
        push(2, 12'h221); push(2, 12'h222);
        cycle();
        Enable = 0;
        repeat (4) cycle();
        Enable = 1;
        drain(30);

        // Counter sweep after 4/4/4/4 words, idx 0..5 back to back.
        do_reset();
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 4; j++) push(p, 12'($urandom));
        drain(40);
        req = 1;
        for (int i = 0; i < 6; i++) begin
            idx = 3'(i);
            cycle();
        end
        req = 0;
        cycle();

        // Counter wrap on p0.
        do_reset();
        for (int j = 0; j < 257; j++) push(0, 12'($urandom));
        drain(400);
        read_cnt(0); read_cnt(4);

        // Reset with a pop in flight.
        push(3, 12'h333); push(3, 12'h334); push(1, 12'h155);
        cycle();
        do_reset();
        for (int i = 0; i < 5; i++) read_cnt(i);

        // Randomized traffic, enable and counter reads.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) != 0) push(int'($urandom_range(0, 3)), 12'($urandom));
            if ($urandom_range(0, 4) == 0) push(int'($urandom_range(0, 3)), 12'($urandom));
            Enable = ($urandom_range(0, 7) != 0);
            req    = ($urandom_range(0, 1) == 1);
            idx    = 3'($urandom_range(0, 7));
            cycle();
        end
        req = 0; Enable = 1;
        drain(4000);
        for (int i = 0; i < 6; i++) read_cnt(i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
